// File: rtl/rah_pkg.sv
// RAH receive-side shared definitions: header layout, sync word, FSM states.
// Imported by rah_hdr_check and rah_decoder; the encoder uses the same header constants.
package rah_pkg;

    localparam logic [15:0] RAH_SYNC = 16'hA55A;

    // Header field placement (SYNC occupies the top SYNC_W bits of the word)
    localparam int SYNC_W  = 16;
    localparam int LEN_LSB = 16;
    localparam int LEN_W   = 16;
    localparam int APP_LSB = 0;
    localparam int APP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DISCARD
    } rah_state_t;

endpackage

// File: rtl/rah_hdr_check.sv
// Combinational RAH header decode: extracts APP_ID and LEN, flags sync/app-range errors.
// Ports: word (in), hdr_ok (out), app_id (out), len (out).
module rah_hdr_check
    import rah_pkg::*;
#(
    parameter int TOTAL_APPS = 8,
    parameter int DATA_WIDTH = 48
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  hdr_ok,
    output logic [APP_W-1:0]      app_id,
    output logic [LEN_W-1:0]      len
);

    logic [SYNC_W-1:0] sync;
    logic              unused_bits;

    assign sync        = word[DATA_WIDTH-1 -: SYNC_W];
    assign len         = word[LEN_LSB +: LEN_W];
    assign app_id      = word[APP_LSB +: APP_W];
    assign unused_bits = ^word;

    // 9-bit compare so TOTAL_APPS=256 accepts every 8-bit id
    assign hdr_ok = (sync == RAH_SYNC)
                 && ({1'b0, app_id} < 9'(TOTAL_APPS));

endmodule

// File: rtl/rah_decoder.sv
// RAH frame decoder: parses MIPI RX frames and strobes payload words to per-app lanes.
// Ports: clk, rst (sync, active-high), mipi_valid/mipi_data/mipi_sof (in), app_full (in),
//        rd_valid/rd_data (out), hdr_err/trunc_err (out pulses), drop_cnt (out), busy (out).
module rah_decoder
    import rah_pkg::*;
#(
    parameter int TOTAL_APPS = 8,
    parameter int DATA_WIDTH = 48,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mipi_valid,
    input  logic [DATA_WIDTH-1:0]            mipi_data,
    input  logic                             mipi_sof,
    input  logic [TOTAL_APPS-1:0]            app_full,
    output logic [TOTAL_APPS-1:0]            rd_valid,
    output logic [TOTAL_APPS*DATA_WIDTH-1:0] rd_data,
    output logic                             hdr_err,
    output logic                             trunc_err,
    output logic [CNT_WIDTH-1:0]             drop_cnt,
    output logic                             busy
);

    localparam int AW = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1;

    rah_state_t            state, state_n;
    logic [AW-1:0]         app, app_n;
    logic [LEN_W-1:0]      rem, rem_n;
    logic [TOTAL_APPS-1:0] valid_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  hdr_err_n, trunc_n;
    logic [CNT_WIDTH-1:0]  cnt_n;

    logic                  hdr_ok;
    logic [APP_W-1:0]      app_id;
    logic [LEN_W-1:0]      len;
    logic                  sof_word, pay_word;
    logic                  unused_app;

    rah_hdr_check #(
        .TOTAL_APPS (TOTAL_APPS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hdr (
        .word   (mipi_data),
        .hdr_ok (hdr_ok),
        .app_id (app_id),
        .len    (len)
    );

    assign sof_word   = mipi_valid && mipi_sof;
    assign pay_word   = mipi_valid && !mipi_sof;
    assign unused_app = ^app_id;

    always_comb begin
        state_n   = state;
        app_n     = app;
        rem_n     = rem;
        valid_n   = '0;
        data_n    = data_q;
        hdr_err_n = 1'b0;
        trunc_n   = 1'b0;
        cnt_n     = drop_cnt;

        unique case (state)
            ST_IDLE, ST_DISCARD, ST_PAYLOAD: begin
                if (sof_word) begin
                    // SOF mid-frame aborts; it reports as truncation only,
                    // so the two error pulses never coincide
                    trunc_n = (state == ST_PAYLOAD);
                    if (hdr_ok) begin
                        app_n   = app_id[AW-1:0];
                        rem_n   = len;
                        state_n = (len == '0) ? ST_IDLE : ST_PAYLOAD;
                    end else begin
                        hdr_err_n = (state != ST_PAYLOAD);
                        state_n   = ST_DISCARD;
                    end
                end else if (pay_word && state == ST_PAYLOAD) begin
                    if (app_full[app]) begin
                        if (drop_cnt != '1) begin
                            cnt_n = drop_cnt + 1'b1;
                        end
                    end else begin
                        valid_n[app] = 1'b1;
                        data_n       = mipi_data;
                    end
                    rem_n = rem - 1'b1;
                    if (rem == LEN_W'(1)) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            app       <= '0;
            rem       <= '0;
            rd_valid  <= '0;
            data_q    <= '0;
            hdr_err   <= 1'b0;
            trunc_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            app       <= app_n;
            rem       <= rem_n;
            rd_valid  <= valid_n;
            data_q    <= data_n;
            hdr_err   <= hdr_err_n;
            trunc_err <= trunc_n;
            drop_cnt  <= cnt_n;
        end
    end

    assign rd_data = {TOTAL_APPS{data_q}};
    assign busy    = (state == ST_PAYLOAD);

endmodule
